// File: rtl/std_div_pipe_if.sv
// std_div_pipe go/done bundle: operands in, quotient/remainder/done out.
// Master drives the request side, slave is the divider.
interface std_div_pipe_if #(
  parameter int WIDTH = 32
);
  logic             go;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic             done;

  modport master (
    output go, left, right,
    input  out_quotient, out_remainder, done
  );

  modport slave (
    input  go, left, right,
    output out_quotient, out_remainder, done
  );
endinterface

// File: rtl/std_div_pipe.sv
// std_div_pipe: iterative restoring divider, one quotient bit per cycle.
// Define STD_DIV_PIPE_SIGNED_EN for two's complement operands.
module std_div_pipe #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  std_div_pipe_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_out_q;
  logic [WIDTH-1:0] r_out_r;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_raw;
  logic [WIDTH-1:0] w_ld_dvd;
  logic [WIDTH-1:0] w_ld_dvs;
  logic [WIDTH-1:0] w_fin_q;
  logic [WIDTH-1:0] w_fin_r;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.go) begin
          w_next   = S_RUN;
          w_accept = 1'b1;
        end
      end
      S_RUN: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_next = S_DONE;
          w_last = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Partial remainder is WIDTH+1 wide; the borrow bit decides the step.
  assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
  assign w_sub     = w_shift - {1'b0, r_dvs};
  assign w_ge      = ~w_sub[WIDTH];
  assign w_rem_nxt = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_q_raw   = {r_dvd[WIDTH-2:0], w_ge};

`ifdef STD_DIV_PIPE_SIGNED_EN
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;
  logic [WIDTH-1:0] r_left;

  assign w_ld_dvd = bus.left[WIDTH-1]  ? -bus.left  : bus.left;
  assign w_ld_dvs = bus.right[WIDTH-1] ? -bus.right : bus.right;

  // MIN/-1 falls out of the negate: magnitude 2^(W-1) wraps back to MIN.
  assign w_fin_q = r_zero  ? '1 :
                   r_neg_q ? -w_q_raw : w_q_raw;
  assign w_fin_r = r_zero  ? r_left :
                   r_neg_r ? -w_rem_nxt : w_rem_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_zero  <= 1'b0;
      r_left  <= '0;
    end else if (w_accept) begin
      r_neg_q <= bus.left[WIDTH-1] ^ bus.right[WIDTH-1];
      r_neg_r <= bus.left[WIDTH-1];
      r_zero  <= (bus.right == '0);
      r_left  <= bus.left;
    end
  end
`else
  assign w_ld_dvd = bus.left;
  assign w_ld_dvs = bus.right;
  assign w_fin_q  = w_q_raw;
  assign w_fin_r  = w_rem_nxt;
`endif

  // Dividend register doubles as the quotient shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_out_q <= '0;
      r_out_r <= '0;
    end else if (w_accept) begin
      r_dvd <= w_ld_dvd;
      r_dvs <= w_ld_dvs;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_dvd <= w_q_raw;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_out_q <= w_fin_q;
        r_out_r <= w_fin_r;
      end
    end
  end

  assign bus.out_quotient  = r_out_q;
  assign bus.out_remainder = r_out_r;
  assign bus.done          = (r_state == S_DONE);
endmodule
